// File: rtl/calc_pkg.sv
// Shared symbol encoding for the calculator keyboard/display path.
// The scan-code converter produces these 4-bit codes and the display back-end
// consumes them, so both sides import this package.
//   symbol_t   : 4-bit symbol code (0-9 digits, A-F operators/controls)
//   CODE_*     : named operator and control codes
//   is_symbol  : true for codes that occupy a display slot (0-D)
package calc_pkg;

    typedef logic [3:0] symbol_t;

    localparam symbol_t CODE_MINUS = 4'hA;
    localparam symbol_t CODE_PLUS  = 4'hB;
    localparam symbol_t CODE_MUL   = 4'hC;
    localparam symbol_t CODE_MOD   = 4'hD;
    localparam symbol_t CODE_BKSP  = 4'hE;
    localparam symbol_t CODE_EMPTY = 4'hF;

    // All segments off on an active-low display.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digits and operators are stored; backspace and empty are not.
    function automatic logic is_symbol(symbol_t code);
        return (code < CODE_BKSP);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational symbol to 7-segment pattern decoder.
// Ports:
//   sym : symbol code to display
//   seg : segments {g,f,e,d,c,b,a}, active-low (0 = lit)
// Backspace and empty codes decode to a blank digit.
module seg7_decode
    import calc_pkg::*;
(
    input  symbol_t    sym,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (sym)
            4'h0:       seg = 7'b1000000;
            4'h1:       seg = 7'b1111001;
            4'h2:       seg = 7'b0100100;
            4'h3:       seg = 7'b0110000;
            4'h4:       seg = 7'b0011001;
            4'h5:       seg = 7'b0010010;
            4'h6:       seg = 7'b0000010;
            4'h7:       seg = 7'b1111000;
            4'h8:       seg = 7'b0000000;
            4'h9:       seg = 7'b0010000;
            CODE_MINUS: seg = 7'b0111111;
            CODE_PLUS:  seg = 7'b0001111;
            CODE_MUL:   seg = 7'b0001001;
            CODE_MOD:   seg = 7'b0011101;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_buffer_driver.sv
// Calculator display back-end: right-entry shift buffer of symbol codes with
// backspace and clear, time-multiplexed onto a common-anode 7-segment display.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   code_in     : symbol code, qualified by the one-cycle code_valid strobe
//   clear       : one-cycle strobe emptying the buffer (wins over code_valid)
//   seg_out     : segments {g,f,e,d,c,b,a}, active-low, registered
//   an_out      : digit anodes, active-low one-hot, registered
//   buffer_full : high while every slot holds a symbol
// Slot 0 is the rightmost digit; new symbols enter there and push older ones left.
module display_buffer_driver
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            code_in,
    input  logic                  code_valid,
    input  logic                  clear,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  buffer_full
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);

    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] LAST_TICK  = RW'(REFRESH_DIV - 1);

    symbol_t                  slot_reg [NUM_DIGITS];
    symbol_t                  slot_next [NUM_DIGITS];
    logic [CW-1:0]            count_reg;
    logic [CW-1:0]            count_next;
    logic [RW-1:0]            refresh_reg;
    logic [IW-1:0]            index_reg;
    logic [6:0]               seg_reg;
    logic [NUM_DIGITS-1:0]    an_reg;
    logic                     full_reg;
    logic                     entry_en;
    logic                     bksp_en;
    logic [6:0]               seg_decoded;

    // clear masks both operations so it always wins in a shared cycle.
    always_comb begin
        entry_en = code_valid && !clear && is_symbol(code_in) && (count_reg != FULL_COUNT);
        bksp_en  = code_valid && !clear && (code_in == CODE_BKSP) && (count_reg != '0);
    end

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (entry_en) begin
            count_next = count_reg + 1'b1;
        end else if (bksp_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Per-slot next value: entry pulls from the right neighbour (or code_in),
    // backspace pulls from the left neighbour (or an empty code at the top).
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        symbol_t from_right;
        symbol_t from_left;

        if (gi == 0) begin : g_first
            assign from_right = code_in;
        end else begin : g_inner_r
            assign from_right = slot_reg[gi-1];
        end

        if (gi == NUM_DIGITS - 1) begin : g_last
            assign from_left = CODE_EMPTY;
        end else begin : g_inner_l
            assign from_left = slot_reg[gi+1];
        end

        assign slot_next[gi] = clear    ? CODE_EMPTY :
                               entry_en ? from_right :
                               bksp_en  ? from_left  :
                                          slot_reg[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                slot_reg[gi] <= CODE_EMPTY;
            end else begin
                slot_reg[gi] <= slot_next[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_COUNT);
        end
    end

    // Digit scan: each digit stays selected for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg <= '0;
            index_reg   <= '0;
        end else if (refresh_reg == LAST_TICK) begin
            refresh_reg <= '0;
            index_reg   <= (index_reg == LAST_INDEX) ? '0 : index_reg + 1'b1;
        end else begin
            refresh_reg <= refresh_reg + 1'b1;
        end
    end

    seg7_decode u_decode (
        .sym (slot_reg[index_reg]),
        .seg (seg_decoded)
    );

    // Pin drivers are registered, so they trail index/buffer state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg <= SEG_BLANK;
            an_reg  <= '1;
        end else begin
            seg_reg <= seg_decoded;
            an_reg  <= ~(NUM_DIGITS'(1) << index_reg);
        end
    end

    assign seg_out     = seg_reg;
    assign an_out      = an_reg;
    assign buffer_full = full_reg;

endmodule

// File: tb/tb_display_buffer_driver.sv
module tb_display_buffer_driver;
    import calc_pkg::*;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    code_in = 4'hF;
    logic          code_valid = 1'b0;
    logic          clear = 1'b0;
    logic [6:0]    seg_out;
    logic [ND-1:0] an_out;
    logic          buffer_full;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    display_buffer_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .clear       (clear),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .buffer_full (buffer_full)
    );

    // Reference model state: slot i lives in slots[4*i +: 4]
    typedef struct packed {
        logic [15:0] slots;
        logic [2:0]  cnt;
        logic [1:0]  tick;
        logic [1:0]  idx;
    } mdl_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       full;
    } obs_t;

    obs_t sb[$];
    mdl_t m = '{slots: 16'hFFFF, cnt: 3'd0, tick: 2'd0, idx: 2'd0};

    // Lit segments {g,f,e,d,c,b,a}, 1 = on
    function automatic logic [6:0] lit_of(input logic [3:0] c);
        case (c)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1000000;
            4'hB: return 7'b1110000;
            4'hC: return 7'b1110110;
            4'hD: return 7'b1100010;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input logic r, input logic v,
                                      input logic cl, input logic [3:0] c);
        mdl_t n;
        if (r) begin
            n = '{slots: 16'hFFFF, cnt: 3'd0, tick: 2'd0, idx: 2'd0};
        end else begin
            n = s;
            if (cl) begin
                n.slots = 16'hFFFF;
                n.cnt   = 3'd0;
            end else if (v && c <= 4'hD && s.cnt < 3'd4) begin
                n.slots = {s.slots[11:0], c};
                n.cnt   = s.cnt + 3'd1;
            end else if (v && c == 4'hE && s.cnt > 3'd0) begin
                n.slots = {4'hF, s.slots[15:4]};
                n.cnt   = s.cnt - 3'd1;
            end
            if (s.tick == 2'(RD - 1)) begin
                n.tick = 2'd0;
                n.idx  = (s.idx == 2'(ND - 1)) ? 2'd0 : s.idx + 2'd1;
            end else begin
                n.tick = s.tick + 2'd1;
            end
        end
        return n;
    endfunction

    function automatic obs_t mdl_obs(input mdl_t s, input mdl_t n, input logic r);
        obs_t o;
        if (r) begin
            o = '{an: 4'hF, seg: 7'h7F, full: 1'b0};
        end else begin
            o.seg  = ~lit_of(s.slots[4*s.idx +: 4]);
            o.an   = ~(4'b0001 << s.idx);
            o.full = (n.cnt == 3'd4);
        end
        return o;
    endfunction

    // Expected pin values for the edge being taken are queued here
    always @(posedge clk) begin
        sb.push_back(mdl_obs(m, mdl_step(m, rst, code_valid, clear, code_in), rst));
        m <= mdl_step(m, rst, code_valid, clear, code_in);
    end

    task automatic drive(input logic [3:0] c, input logic v, input logic cl);
        @(negedge clk);
        code_in    = c;
        code_valid = v;
        clear      = cl;
    endtask

    task automatic idle();
        drive(4'hF, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({an_out, seg_out, buffer_full} !== {4'hF, 7'h7F, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold: got an=%b seg=%b full=%b, want an=1111 seg=1111111 full=0",
                         an_out, seg_out, buffer_full);
            end
        end
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        vectors++;
        if ({an_out, seg_out} !== {4'b1110, 7'h7F}) begin
            miscompares++;
            $display("FAIL reset_first: got an=%b seg=%b, want an=1110 seg=1111111", an_out, seg_out);
        end
        e = sb.pop_front();
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL reset_scan: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({an_out, seg_out, buffer_full} !== e) begin
                    miscompares++;
                    $display("FAIL reset_scan: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                             an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                end
            end
        end
    endtask

    task automatic test_entry();
        obs_t e;
        bit   seen = 0;
        drive(4'h0, 1'b0, 1'b1);
        drive(4'h1, 1'b1, 1'b0);
        drive(4'h2, 1'b1, 1'b0);
        drive(4'h3, 1'b1, 1'b0);
        idle();
        sb.delete();
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL entry_scan: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({an_out, seg_out, buffer_full} !== e) begin
                    miscompares++;
                    $display("FAIL entry_scan: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                             an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                end
            end
            if (an_out == 4'b1110 && !seen) begin
                seen = 1;
                vectors++;
                if (seg_out !== 7'b0110000 || buffer_full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL entry_slot0: got seg=%b full=%b, want seg=0110000 full=0",
                             seg_out, buffer_full);
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL entry_slot0: digit 0 never selected within 20 cycles");
        end
    endtask

    task automatic test_full();
        obs_t e;
        drive(4'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) drive(4'(i), 1'b1, 1'b0);
        idle();
        sb.delete();
        @(negedge clk);
        vectors++;
        if (buffer_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flag: got full=%b, want full=1", buffer_full);
        end
        e = sb.pop_front();
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL full_scan: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({an_out, seg_out, buffer_full} !== e) begin
                    miscompares++;
                    $display("FAIL full_scan: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                             an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                end
            end
        end
    endtask

    task automatic test_backspace();
        obs_t e;
        // Starts from {1,2,3,4}: one, four, then one extra backspace
        for (int step = 0; step < 3; step++) begin
            repeat (step == 1 ? 4 : 1) drive(4'hE, 1'b1, 1'b0);
            idle();
            sb.delete();
            repeat (18) begin
                @(negedge clk);
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bksp_scan%0d: no expected entry", step);
                end else begin
                    e = sb.pop_front();
                    if ({an_out, seg_out, buffer_full} !== e) begin
                        miscompares++;
                        $display("FAIL bksp_scan%0d: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                                 step, an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                    end
                end
            end
        end
    endtask

    task automatic test_clear_priority();
        obs_t e;
        drive(4'h8, 1'b1, 1'b0);
        drive(4'h9, 1'b1, 1'b0);
        drive(4'h7, 1'b1, 1'b1);
        drive(4'h6, 1'b1, 1'b0);
        drive(4'hE, 1'b1, 1'b0);
        idle();
        sb.delete();
        repeat (18) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL clear_scan: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({an_out, seg_out, buffer_full} !== e) begin
                    miscompares++;
                    $display("FAIL clear_scan: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                             an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                end
            end
        end
    endtask

    task automatic test_operators();
        obs_t e;
        drive(4'h0, 1'b0, 1'b1);
        drive(CODE_MINUS, 1'b1, 1'b0);
        drive(CODE_PLUS,  1'b1, 1'b0);
        drive(CODE_MUL,   1'b1, 1'b0);
        drive(CODE_MOD,   1'b1, 1'b0);
        drive(CODE_EMPTY, 1'b1, 1'b0);
        idle();
        sb.delete();
        repeat (18) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL ops_scan: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({an_out, seg_out, buffer_full} !== e) begin
                    miscompares++;
                    $display("FAIL ops_scan: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                             an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t e;
        drive(4'h0, 1'b0, 1'b1);
        drive(4'h5, 1'b1, 1'b0);
        drive(4'h6, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        code_in = 4'h9;
        @(negedge clk);
        rst = 1'b0;
        code_valid = 1'b0;
        sb.delete();
        repeat (18) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL midrst_scan: no expected entry");
            end else begin
                e = sb.pop_front();
                if ({an_out, seg_out, buffer_full} !== e) begin
                    miscompares++;
                    $display("FAIL midrst_scan: got an=%b seg=%b full=%b, want an=%b seg=%b full=%b",
                             an_out, seg_out, buffer_full, e.an, e.seg, e.full);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        $display("test_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
        test_entry();
        $display("test_entry done: vectors=%0d miscompares=%0d", vectors, miscompares);
        test_full();
        $display("test_full done: vectors=%0d miscompares=%0d", vectors, miscompares);
        test_backspace();
        $display("test_backspace done: vectors=%0d miscompares=%0d", vectors, miscompares);
        test_clear_priority();
        $display("test_clear_priority done: vectors=%0d miscompares=%0d", vectors, miscompares);
        test_operators();
        $display("test_operators done: vectors=%0d miscompares=%0d", vectors, miscompares);
        test_mid_reset();
        $display("test_mid_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
